// File: rtl/branch_reduce_pkg.sv
// Shared types for the branch_reduce kernel: FSM state and per-element branch code.
package branch_reduce_pkg;

    typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

    typedef enum logic [1:0] {BR_ADD, BR_SUB, BR_INC, BR_NOP} br_code_t;

endpackage

// File: rtl/branch_reduce_eval.sv
// Combinational classifier: picks the branch for one element and computes the
// updated accumulator.
module branch_reduce_eval
    import branch_reduce_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RESULT_W = 16,
    parameter int THRESH   = 4
) (
    input  logic [DATA_W-1:0]   i_x,
    input  logic                i_mode,
    input  logic [RESULT_W-1:0] i_acc,
    output br_code_t            o_code,
    output logic [RESULT_W-1:0] o_acc_next
);

    logic [RESULT_W-1:0] w_xe;

    assign w_xe = RESULT_W'(i_x);

    // Odd elements follow the latched mode; even ones only count when above THRESH.
    always_comb begin
        o_code     = BR_NOP;
        o_acc_next = i_acc;
        if (i_x[0]) begin
            if (i_mode) begin
                o_code     = BR_ADD;
                o_acc_next = i_acc + w_xe;
            end else begin
                o_code     = BR_SUB;
                o_acc_next = i_acc - w_xe;
            end
        end else if (w_xe > RESULT_W'(THRESH)) begin
            o_code     = BR_INC;
            o_acc_next = i_acc + 1'b1;
        end
    end

endmodule

// File: rtl/branch_reduce.sv
// Start/done kernel: walks len elements of a synchronous RAM, accumulates per
// branch code, optionally writes the code back, and pulses w_enable when finished.
module branch_reduce
    import branch_reduce_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RESULT_W  = 16,
    parameter int THRESH    = 4,
    parameter int WRITEBACK = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                r_enable,
    input  logic                mode,
    input  logic [RESULT_W-1:0] init,
    input  logic [ADDR_W:0]     len,
    output logic                arrWEnable,
    output logic [ADDR_W-1:0]   arrAddr,
    input  logic [DATA_W-1:0]   arrRData,
    output logic [DATA_W-1:0]   arrWData,
    output logic                w_enable,
    output logic [RESULT_W-1:0] result
);

    state_t              r_state;
    logic                r_mode;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_i;
    logic [RESULT_W-1:0] r_acc;
    logic [RESULT_W-1:0] r_result;
    logic                r_w_enable;

    br_code_t            w_code;
    logic [RESULT_W-1:0] w_acc_next;
    logic [ADDR_W:0]     w_i_next;
    logic [DATA_W-1:0]   w_code_ext;

    branch_reduce_eval #(
        .DATA_W  (DATA_W),
        .RESULT_W(RESULT_W),
        .THRESH  (THRESH)
    ) u_eval (
        .i_x       (arrRData),
        .i_mode    (r_mode),
        .i_acc     (r_acc),
        .o_code    (w_code),
        .o_acc_next(w_acc_next)
    );

    assign w_i_next = r_i + 1'b1;

    always_comb begin
        w_code_ext      = '0;
        w_code_ext[1:0] = w_code;
    end

    // The address holds i through READ and EXEC, so the writeback in EXEC lands on
    // the element just read; write strobe/data are combinational because the code
    // only exists once the RAM data arrives in EXEC.
    assign arrAddr    = r_i[ADDR_W-1:0];
    assign arrWEnable = (WRITEBACK != 0) && (r_state == EXEC);
    assign arrWData   = arrWEnable ? w_code_ext : '0;
    assign w_enable   = r_w_enable;
    assign result     = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode     <= 1'b0;
            r_len      <= '0;
            r_i        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_w_enable <= 1'b0;
        end else begin
            r_w_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_enable) begin
                        r_mode  <= mode;
                        r_len   <= len;
                        r_acc   <= init;
                        r_i     <= '0;
                        r_state <= (len == '0) ? DONE : READ;
                    end
                end
                READ: r_state <= EXEC;
                EXEC: begin
                    r_acc   <= w_acc_next;
                    r_i     <= w_i_next;
                    r_state <= (w_i_next == r_len) ? DONE : READ;
                end
                DONE: begin
                    r_result   <= r_acc;
                    r_w_enable <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_reduce.sv
// Directed bench: three kernels (two plain, one with writeback) each on a 1-cycle RAM model.
module tb_branch_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  r_en = '0;
    logic [2:0]  md = '0;
    logic [15:0] init_v [3];
    logic [4:0]  len_v [3];
    logic [2:0]  we;
    logic [3:0]  addr [3];
    logic [7:0]  rd [3];
    logic [7:0]  wd [3];
    logic [2:0]  w_en;
    logic [15:0] res [3];

    logic [7:0]  mem [3][16];
    logic [7:0]  img [3][16];
    logic        ld = 1'b0;

    int checks = 0;
    int failures = 0;
    int first_c [3];
    int pulse_c [3];
    int we_c [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        branch_reduce #(
            .DATA_W(8), .ADDR_W(4), .RESULT_W(16), .THRESH(4),
            .WRITEBACK((g == 2) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .r_enable(r_en[g]), .mode(md[g]),
            .init(init_v[g]), .len(len_v[g]), .arrWEnable(we[g]),
            .arrAddr(addr[g]), .arrRData(rd[g]), .arrWData(wd[g]),
            .w_enable(w_en[g]), .result(res[g])
        );

        always @(posedge clk) begin
            if (ld) begin
                for (int j = 0; j < 16; j++) mem[g][j] <= img[g][j];
            end else if (we[g]) begin
                mem[g][addr[g]] <= wd[g];
            end
            rd[g] <= mem[g][addr[g]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_img(input int g, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3);
        for (int j = 0; j < 16; j++) img[g][j] = 8'h00;
        img[g][0] = a0; img[g][1] = a1; img[g][2] = a2; img[g][3] = a3;
    endtask

    task automatic load();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic setup(input int g, input logic m, input logic [15:0] iv, input logic [4:0] l);
        md[g] = m; init_v[g] = iv; len_v[g] = l;
    endtask

    // Start the selected kernels on one edge, then watch budget cycles;
    // first_c counts edges after acceptance until w_enable is seen.
    task automatic go(input logic [2:0] sel, input int budget, input int busy_at);
        for (int g = 0; g < 3; g++) begin first_c[g] = -1; pulse_c[g] = 0; we_c[g] = 0; end
        @(negedge clk); r_en = sel;
        @(posedge clk); #1 r_en = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            r_en = (k == busy_at) ? sel : 3'b000;
            for (int g = 0; g < 3; g++) begin
                if (sel[g] && w_en[g]) begin
                    if (first_c[g] < 0) first_c[g] = k;
                    pulse_c[g]++;
                end
                if (sel[g] && we[g]) we_c[g]++;
            end
        end
        r_en = '0;
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            setup(g, 1'b0, 16'h0, 5'd0);
            set_img(g, 8'd3, 8'd6, 8'd2, 8'd5);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_w_enable", {29'b0, w_en}, 32'h0);
        chk("rst_result", {16'b0, res[0]}, 32'h0);
        chk("rst_addr", {28'b0, addr[2]}, 32'h0);
        chk("rst_we", {29'b0, we}, 32'h0);
        chk("rst_wdata", {24'b0, wd[2]}, 32'h0);
        @(negedge clk); rst = 1'b0;
        load();

        // Case 1 on A and case 5 (writeback) on W together
        setup(0, 1'b1, 16'd10, 5'd4);
        setup(2, 1'b1, 16'd10, 5'd4);
        go(3'b101, 16, -1);
        chk("c1_result", {16'b0, res[0]}, 32'd19);
        chk("c1_latency", first_c[0], 32'd9);
        chk("c1_pulses", pulse_c[0], 32'd1);
        chk("c5_result", {16'b0, res[2]}, 32'd19);
        chk("c5_we_cycles", we_c[2], 32'd4);
        chk("c5_mem0", {24'b0, mem[2][0]}, 32'd0);
        chk("c5_mem1", {24'b0, mem[2][1]}, 32'd2);
        chk("c5_mem2", {24'b0, mem[2][2]}, 32'd3);
        chk("c5_mem3", {24'b0, mem[2][3]}, 32'd0);

        // Case 2: A mode=0 and B mode=1 concurrently
        setup(0, 1'b0, 16'd10, 5'd4);
        setup(1, 1'b1, 16'd10, 5'd4);
        go(3'b011, 16, -1);
        chk("c2_result_a", {16'b0, res[0]}, 32'd3);
        chk("c2_result_b", {16'b0, res[1]}, 32'd19);
        chk("c2_lat_a", first_c[0], 32'd9);
        chk("c2_lat_b", first_c[1], 32'd9);

        // Case 3: len=0 on A and W
        setup(0, 1'b1, 16'd5, 5'd0);
        setup(2, 1'b1, 16'd5, 5'd0);
        go(3'b101, 6, -1);
        chk("c3_result", {16'b0, res[0]}, 32'd5);
        chk("c3_latency", first_c[0], 32'd1);
        chk("c3_pulses", pulse_c[0], 32'd1);
        chk("c3_no_write", we_c[2], 32'd0);
        chk("c3_result_w", {16'b0, res[2]}, 32'd5);

        // Case 4: wrap below zero
        set_img(0, 8'd1, 8'd0, 8'd0, 8'd0);
        load();
        setup(0, 1'b0, 16'd0, 5'd1);
        go(3'b001, 8, -1);
        chk("c4_result", {16'b0, res[0]}, 32'hFFFF);
        chk("c4_latency", first_c[0], 32'd3);

        // Case 6a: start ignored while busy
        set_img(0, 8'd3, 8'd6, 8'd2, 8'd5);
        load();
        setup(0, 1'b1, 16'd10, 5'd4);
        go(3'b001, 24, 3);
        chk("c6_busy_result", {16'b0, res[0]}, 32'd19);
        chk("c6_busy_pulses", pulse_c[0], 32'd1);
        chk("c6_busy_latency", first_c[0], 32'd9);

        // Case 6b: reset mid-run aborts without a done pulse
        @(negedge clk); r_en[0] = 1'b1;
        @(posedge clk); #1 r_en[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("c6_rst_result", {16'b0, res[0]}, 32'd0);
        chk("c6_rst_w_enable", {31'b0, w_en[0]}, 32'd0);
        chk("c6_rst_addr", {28'b0, addr[0]}, 32'd0);
        @(negedge clk); rst = 1'b0;
        pulse_c[0] = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (w_en[0]) pulse_c[0]++;
        end
        chk("c6_no_done_after_rst", pulse_c[0], 32'd0);
        go(3'b001, 16, -1);
        chk("c6_restart_result", {16'b0, res[0]}, 32'd19);
        chk("c6_restart_pulses", pulse_c[0], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
